dm_resp: RTL



---
 rtl/dm_resp_pkg.sv | 30 +++
 rtl/dm_lane.sv | 66 ++++++
 rtl/dm_resp.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dm_resp_pkg.sv
// Shared definitions for the data-memory responder: access-type codes, FSM states
// and the request-validity helpers used by the responder and the control unit.
package dm_resp_pkg;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dm_state_e;

    function automatic logic dm_type_reserved(input logic [2:0] dm_type);
        return dm_type > DM_BU;
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] dm_type, input logic [1:0] addr_lo);
        case (dm_type)
            DM_W:        return addr_lo != 2'b00;
            DM_H, DM_HU: return addr_lo[0];
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational lane logic: merges sub-word store data into a memory word and
// extracts/extends the addressed lane for loads.
module dm_lane
    import dm_resp_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dm_type,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [7:0]  lane_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Store data is replicated across lanes so each byte enable picks its own copy.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (dm_type)
            DM_W: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
            DM_H, DM_HU: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            DM_B, DM_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi]        = mem_word[8*gi +: 8];
            assign store_word[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : mem_word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane_bytes[addr_lo];
    assign sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = '0;
        case (dm_type)
            DM_W:    load_data = mem_word;
            DM_H:    load_data = {{16{sel_half[15]}}, sel_half};
            DM_HU:   load_data = {16'h0000, sel_half};
            DM_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            DM_BU:   load_data = {24'h000000, sel_byte};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: one request at a time over valid/ready, programmable wait
// states, then a single access cycle and a held response until it is accepted.
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int DEPTH       = 3072,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    dm_state_e   state_reg;
    logic [CW-1:0] cnt_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;

    logic        lat_we_reg;
    logic [31:0] lat_addr_reg;
    logic [31:0] lat_wdata_reg;
    logic [2:0]  lat_type_reg;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic          addr_oob;
    logic          acc_err;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic [31:0]   store_word;
    logic [31:0]   load_data;

    assign word_idx = lat_addr_reg[AW+1:2];
    assign addr_oob = {2'b00, lat_addr_reg[31:2]} >= 32'(DEPTH);
    assign acc_err  = dm_type_reserved(lat_type_reg)
                   || dm_misaligned(lat_type_reg, lat_addr_reg[1:0])
                   || addr_oob;
    assign rd_word  = addr_oob ? 32'h0 : mem[word_idx];
    assign mem_we   = (state_reg == ST_ACCESS) && lat_we_reg && !acc_err;

    dm_lane u_lane (
        .mem_word   (rd_word),
        .wdata      (lat_wdata_reg),
        .addr_lo    (lat_addr_reg[1:0]),
        .dm_type    (lat_type_reg),
        .store_word (store_word),
        .load_data  (load_data)
    );

    // Reset clears every word, so the array cannot map onto a block RAM primitive.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[word_idx] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            lat_type_reg  <= DM_W;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        lat_we_reg    <= req_we;
                        lat_addr_reg  <= req_addr;
                        lat_wdata_reg <= req_wdata;
                        lat_type_reg  <= req_type;
                        req_ready_reg <= 1'b0;
                        cnt_reg       <= CNT_INIT;
                        state_reg     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_ACCESS;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= acc_err;
                    rsp_rdata_reg <= (acc_err || lat_we_reg) ? 32'h0 : load_data;
                    state_reg     <= ST_RESP;
                end
                ST_RESP: begin
                    // req_ready only rises here, so a request offered alongside the
                    // response handshake waits for the next IDLE cycle.
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
